// File: rtl/axi4_lite_cmd_mst.sv
// axi4_lite_cmd_mst
//   Command-driven AXI4-Lite master. It accepts one read or write command on a
//   valid/ready stream and runs the matching AXI4-Lite transaction. It then
//   returns the response on a second valid/ready stream. Only one transaction
//   is in flight at a time. A watchdog ends any transaction that the slave
//   never completes, and the block then parks in a hang state until reset.
//
// Ports
//   i_clk, i_sync_rst           clock; synchronous active-high reset
//   i_cmd_*, o_cmd_ready        command stream (o_cmd_ready high only when idle)
//   o_rsp_*, i_rsp_ready        response stream (fields held until accepted)
//   axi_aw* / axi_w* / axi_b*   AXI4-Lite write channels (master side)
//   axi_ar* / axi_r*            AXI4-Lite read channels (master side)
module axi4_lite_cmd_mst #(
  parameter int unsigned ADDR_BIT_WIDTH = 32,
  parameter int unsigned DATA_BIT_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_sync_rst,
  // command stream
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wr_data,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wr_strb,
  // response stream
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_is_wr,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rd_data,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_rsp_timeout,
  // AXI4-Lite master port
  output logic [ADDR_BIT_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]                  axi_awprot,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [DATA_BIT_WIDTH-1:0]   axi_wdata,
  output logic [DATA_BIT_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic [ADDR_BIT_WIDTH-1:0]   axi_araddr,
  output logic [2:0]                  axi_arprot,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [DATA_BIT_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
);

  localparam int unsigned StrbW = DATA_BIT_WIDTH / 8;
  localparam int unsigned WdW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry is detected one count early so the response appears as the count reaches the limit.
  localparam logic [WdW-1:0] WdLast = (TIMEOUT_CYCLES > 0) ? WdW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    StIdle, StWrAwW, StWrB, StRdAr, StRdR, StRsp, StHang
  } state_e;

  state_e state_q, state_d;

  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      bready_q, bready_d;
  logic                      rready_q, rready_d;
  logic                      cmd_is_wr_q, cmd_is_wr_d;
  logic [ADDR_BIT_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_BIT_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [StrbW-1:0]          cmd_strb_q, cmd_strb_d;
  logic [WdW-1:0]            wd_q, wd_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_is_wr_q, rsp_is_wr_d;
  logic [DATA_BIT_WIDTH-1:0] rsp_rd_data_q, rsp_rd_data_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      rsp_timeout_q, rsp_timeout_d;

  logic cmd_accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;
  logic aw_done, w_done, active, wd_expire, timeout_set;

  assign o_cmd_ready = (state_q == StIdle);
  assign cmd_accept  = i_cmd_valid && o_cmd_ready;
  assign aw_hs       = awvalid_q && axi_awready;
  assign w_hs        = wvalid_q && axi_wready;
  assign ar_hs       = arvalid_q && axi_arready;
  assign b_hs        = axi_bvalid && bready_q;
  assign r_hs        = axi_rvalid && rready_q;
  assign rsp_hs      = (state_q == StRsp) && i_rsp_ready;
  // A channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done     = !awvalid_q || aw_hs;
  assign w_done      = !wvalid_q || w_hs;
  assign active      = (state_q == StWrAwW) || (state_q == StWrB) ||
                       (state_q == StRdAr) || (state_q == StRdR);
  assign wd_expire   = (TIMEOUT_CYCLES > 0) && active && (wd_q == WdLast);

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q       <= StIdle;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      cmd_is_wr_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      cmd_strb_q    <= '0;
      wd_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_is_wr_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      cmd_is_wr_q   <= cmd_is_wr_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      cmd_strb_q    <= cmd_strb_d;
      wd_q          <= wd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_is_wr_q   <= rsp_is_wr_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state logic; a completing handshake always beats watchdog expiry.
  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_accept) state_d = i_cmd_is_wr ? StWrAwW : StRdAr;
      end
      StWrAwW: begin
        if (aw_done && w_done) begin
          state_d = StWrB;
        end else if (wd_expire) begin
          state_d     = StRsp;
          timeout_set = 1'b1;
        end
      end
      StWrB: begin
        if (b_hs) begin
          state_d = StRsp;
        end else if (wd_expire) begin
          state_d     = StRsp;
          timeout_set = 1'b1;
        end
      end
      StRdAr: begin
        if (ar_hs) begin
          state_d = StRdR;
        end else if (wd_expire) begin
          state_d     = StRsp;
          timeout_set = 1'b1;
        end
      end
      StRdR: begin
        if (r_hs) begin
          state_d = StRsp;
        end else if (wd_expire) begin
          state_d     = StRsp;
          timeout_set = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_hs) state_d = rsp_timeout_q ? StHang : StIdle;
      end
      StHang:  state_d = StHang;
      default: state_d = StIdle;
    endcase
  end

  // Registered-output next values
  always_comb begin
    // Valids stay up until their handshake, even after a timeout, since AXI forbids withdrawal.
    awvalid_d = (awvalid_q && !axi_awready) || (cmd_accept && i_cmd_is_wr);
    wvalid_d  = (wvalid_q && !axi_wready) || (cmd_accept && i_cmd_is_wr);
    arvalid_d = (arvalid_q && !axi_arready) || (cmd_accept && !i_cmd_is_wr);
    bready_d  = (state_d == StWrB);
    rready_d  = (state_d == StRdR);

    cmd_is_wr_d = cmd_is_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_strb_d  = cmd_strb_q;
    if (cmd_accept) begin
      cmd_is_wr_d = i_cmd_is_wr;
      cmd_addr_d  = i_cmd_addr;
      cmd_data_d  = i_cmd_wr_data;
      cmd_strb_d  = i_cmd_wr_strb;
    end

    wd_d = wd_q;
    if (cmd_accept) begin
      wd_d = '0;
    end else if (active) begin
      wd_d = wd_q + WdW'(1);
    end

    rsp_valid_d   = rsp_valid_q && !rsp_hs;
    rsp_is_wr_d   = rsp_is_wr_q;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q != StRsp) begin
      if (b_hs) begin
        rsp_valid_d   = 1'b1;
        rsp_is_wr_d   = 1'b1;
        rsp_rd_data_d = '0;
        rsp_resp_d    = axi_bresp;
        rsp_timeout_d = 1'b0;
      end else if (r_hs) begin
        rsp_valid_d   = 1'b1;
        rsp_is_wr_d   = 1'b0;
        rsp_rd_data_d = axi_rdata;
        rsp_resp_d    = axi_rresp;
        rsp_timeout_d = 1'b0;
      end else if (timeout_set) begin
        rsp_valid_d   = 1'b1;
        rsp_is_wr_d   = cmd_is_wr_q;
        rsp_rd_data_d = '0;
        rsp_resp_d    = 2'b10;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  assign axi_awaddr    = cmd_addr_q;
  assign axi_awprot    = 3'b000;
  assign axi_awvalid   = awvalid_q;
  assign axi_wdata     = cmd_data_q;
  assign axi_wstrb     = cmd_strb_q;
  assign axi_wvalid    = wvalid_q;
  assign axi_bready    = bready_q;
  assign axi_araddr    = cmd_addr_q;
  assign axi_arprot    = 3'b000;
  assign axi_arvalid   = arvalid_q;
  assign axi_rready    = rready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_is_wr   = rsp_is_wr_q;
  assign o_rsp_rd_data = rsp_rd_data_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// Directed bench for axi4_lite_cmd_mst with a small AXI4-Lite memory slave.
module tb_axi4_lite_cmd_mst;

  localparam int TO = 16;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] rd;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_cmd_valid, o_cmd_ready, i_cmd_is_wr;
  logic [31:0] i_cmd_addr, i_cmd_wr_data;
  logic [3:0]  i_cmd_wr_strb;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_is_wr, o_rsp_timeout;
  logic [31:0] o_rsp_rd_data;
  logic [1:0]  o_rsp_resp;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_bresp, axi_rresp;

  axi4_lite_cmd_mst #(
    .ADDR_BIT_WIDTH(32),
    .DATA_BIT_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk         (clk),
    .i_sync_rst    (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_is_wr   (i_cmd_is_wr),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wr_data (i_cmd_wr_data),
    .i_cmd_wr_strb (i_cmd_wr_strb),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_is_wr   (o_rsp_is_wr),
    .o_rsp_rd_data (o_rsp_rd_data),
    .o_rsp_resp    (o_rsp_resp),
    .o_rsp_timeout (o_rsp_timeout),
    .axi_awaddr    (axi_awaddr),
    .axi_awprot    (axi_awprot),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .axi_bresp     (axi_bresp),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .axi_araddr    (axi_araddr),
    .axi_arprot    (axi_arprot),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_rdata     (axi_rdata),
    .axi_rresp     (axi_rresp),
    .axi_rvalid    (axi_rvalid),
    .axi_rready    (axi_rready)
  );

  // Memory slave with knobs for awready delay, bvalid delay and a dead AR channel.
  int          aw_wait = 0;
  int          b_wait = 0;
  logic        ar_never = 1'b0;
  logic        aw_got, w_got, b_pend, bvalid_r, rvalid_r;
  logic [31:0] aw_addr_l, w_data_l, rdata_r;
  logic [3:0]  w_strb_l;
  int          aw_cnt, b_cnt, b_beats;
  logic [31:0] mem [0:15];

  assign axi_awready = axi_awvalid && !aw_got && (aw_cnt >= aw_wait);
  assign axi_wready  = axi_wvalid && !w_got;
  assign axi_arready = axi_arvalid && !ar_never && !rvalid_r;
  assign axi_bvalid  = bvalid_r;
  assign axi_bresp   = 2'b00;
  assign axi_rvalid  = rvalid_r;
  assign axi_rresp   = 2'b00;
  assign axi_rdata   = rdata_r;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      aw_cnt <= 0; b_cnt <= 0; b_beats <= 0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; rdata_r <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (axi_awvalid && axi_awready) begin
        aw_addr_l <= axi_awaddr; aw_got <= 1'b1; aw_cnt <= 0;
      end else if (axi_awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (axi_wvalid && axi_wready) begin
        w_data_l <= axi_wdata; w_strb_l <= axi_wstrb; w_got <= 1'b1;
      end
      if (aw_got && w_got && !b_pend && !bvalid_r) begin
        for (int i = 0; i < 4; i++)
          if (w_strb_l[i]) mem[aw_addr_l[5:2]][8*i +: 8] <= w_data_l[8*i +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
      end
      if (b_pend) begin
        if (b_cnt >= b_wait) begin
          bvalid_r <= 1'b1; b_pend <= 1'b0;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (bvalid_r && axi_bready) begin
        bvalid_r <= 1'b0; b_beats <= b_beats + 1;
      end
      if (axi_arvalid && axi_arready) begin
        rdata_r <= mem[axi_araddr[5:2]]; rvalid_r <= 1'b1;
      end else if (rvalid_r && axi_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Cycle counter and cycle of the last B/R handshake.
  int cyc = 0;
  int hs_cyc = -100;
  always @(posedge clk) begin
    if ((axi_bvalid && axi_bready) || (axi_rvalid && axi_rready)) hs_cyc <= cyc;
    cyc <= cyc + 1;
  end

  int   vectors = 0;
  int   miscompares = 0;
  rsp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a posedge; acc is the cycle the command was accepted.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input rsp_t exp, output int acc);
    logic rdy;
    int   c;
    sb.push_back(exp);
    i_cmd_valid   = 1'b1;
    i_cmd_is_wr   = wr;
    i_cmd_addr    = addr;
    i_cmd_wr_data = data;
    i_cmd_wr_strb = strb;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      rdy = o_cmd_ready;
      c   = cyc;
      @(posedge clk);
      #1;
      if (rdy) acc = c;
    end
    i_cmd_valid = 1'b0;
    chk("cmd_accepted", 64'(acc >= 0), 1);
  endtask

  task automatic get_rsp(input int hold, input int acc, input logic expect_idle);
    rsp_t e;
    logic found = 1'b0;
    i_rsp_ready = (hold == 0);
    for (int i = 0; i < 100 && !found; i++) begin
      if (o_rsp_valid) begin
        found = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("rsp_seen", 64'(found), 1);
    if (found) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 1);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("rsp_is_wr", 64'(o_rsp_is_wr), 64'(e.is_wr));
      chk("rsp_rd_data", 64'(o_rsp_rd_data), 64'(e.rd));
      chk("rsp_resp", 64'(o_rsp_resp), 64'(e.resp));
      chk("rsp_timeout", 64'(o_rsp_timeout), 64'(e.to));
      if (e.to) chk("timeout_latency", 64'(cyc - acc), TO + 1);
      else      chk("rsp_latency", 64'(cyc - hs_cyc), 1);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("rsp_hold_stable",
            {o_rsp_valid, o_cmd_ready, o_rsp_is_wr, o_rsp_rd_data, o_rsp_resp, o_rsp_timeout},
            {1'b1, 1'b0, e.is_wr, e.rd, e.resp, e.to});
      end
      i_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      i_rsp_ready = 1'b0;
      chk("post_rsp", {o_rsp_valid, o_cmd_ready}, {1'b0, expect_idle});
    end
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int acc;
    send_cmd(1'b1, addr, data, strb, {1'b1, 32'h0, 2'b00, 1'b0}, acc);
    get_rsp(0, acc, 1'b1);
  endtask

  task automatic do_rd(input logic [31:0] addr, input logic [31:0] exp_data, input int hold);
    int acc;
    send_cmd(1'b0, addr, 32'h0, 4'h0, {1'b0, exp_data, 2'b00, 1'b0}, acc);
    chk("arvalid_next_cycle", {axi_arvalid, o_cmd_ready}, 2'b10);
    get_rsp(hold, acc, 1'b1);
  endtask

  initial begin
    int   acc, awc, wc, b0;
    logic seen_ready;
    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_is_wr = 1'b0; i_cmd_addr = '0;
    i_cmd_wr_data = '0; i_cmd_wr_strb = '0; i_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready,
                       o_rsp_valid, o_rsp_is_wr, o_rsp_timeout, o_cmd_ready}, 9'b000000001);
    chk("reset_rsp_data", {o_rsp_rd_data, o_rsp_resp}, 0);
    rst = 1'b0;

    // Write then read back, with minimum-latency valids.
    send_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, {1'b1, 32'h0, 2'b00, 1'b0}, acc);
    chk("aw_w_valid_next_cycle", {axi_awvalid, axi_wvalid, o_cmd_ready}, 3'b110);
    get_rsp(0, acc, 1'b1);
    do_rd(32'h4, 32'hDEADBEEF, 0);

    // Byte-strobed partial write.
    do_wr(32'h8, 32'h11223344, 4'hF);
    do_wr(32'h8, 32'hAAAAAAAA, 4'b0010);
    do_rd(32'h8, 32'h1122AA44, 0);

    // Response back-pressure for 10 cycles.
    do_rd(32'h8, 32'h1122AA44, 10);

    // awready delayed: AW and W complete independently, one B beat.
    aw_wait = 2;
    b0 = b_beats;
    send_cmd(1'b1, 32'hC, 32'h55, 4'hF, {1'b1, 32'h0, 2'b00, 1'b0}, acc);
    awc = 0;
    wc  = 0;
    for (int i = 0; i < 10 && (axi_awvalid || axi_wvalid); i++) begin
      awc += int'(axi_awvalid);
      wc  += int'(axi_wvalid);
      @(posedge clk);
      #1;
    end
    chk("awvalid_cycles", 64'(awc), 3);
    chk("wvalid_cycles", 64'(wc), 1);
    get_rsp(0, acc, 1'b1);
    chk("b_beats", 64'(b_beats - b0), 1);
    aw_wait = 0;
    do_rd(32'hC, 32'h55, 0);

    // bvalid arrives in the very cycle the watchdog would expire: handshake wins.
    b_wait = 12;
    do_wr(32'h14, 32'h99, 4'hF);
    b_wait = 0;
    do_rd(32'h14, 32'h99, 0);

    // Reset while waiting in WR_B.
    b_wait = 5;
    send_cmd(1'b1, 32'h10, 32'h77, 4'hF, {1'b1, 32'h0, 2'b00, 1'b0}, acc);
    for (int i = 0; i < 20 && !axi_bready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wr_b_reached", 64'(axi_bready), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_txn_reset", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready,
                          o_rsp_valid, o_cmd_ready}, 7'b0000001);
    rst = 1'b0;
    sb.delete();
    b_wait = 0;
    do_rd(32'h4, 32'h0, 0);

    // Watchdog: AR never accepted.
    ar_never = 1'b1;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0, {1'b0, 32'h0, 2'b10, 1'b1}, acc);
    get_rsp(0, acc, 1'b0);
    seen_ready = 1'b0;
    i_cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      seen_ready |= o_cmd_ready;
      @(posedge clk);
      #1;
    end
    i_cmd_valid = 1'b0;
    chk("hang_cmd_ready", 64'(seen_ready), 0);
    chk("hang_arvalid_held", {axi_arvalid, o_rsp_valid}, 2'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("hang_left_by_reset", {o_cmd_ready, axi_arvalid}, 2'b10);
    ar_never = 1'b0;
    do_rd(32'h8, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench stalled");
  end

endmodule
